// File: rtl/timer_unit.sv
// timer_unit: memory-mapped 32-bit timer with prescaler, compare match, auto-reload or one-shot, level irq
module timer_unit #(
    parameter int PRESCALE_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sel,
    input  logic        i_we,
    input  logic [3:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_irq
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0] state, state_nx;
    logic ctrl_en, ctrl_auto, ctrl_irq_en, match, running, done;
    logic [PRESCALE_W-1:0] prescale, psc;
    logic [31:0] cmp, cnt;
    logic wr, ctrl_wr, cmp_wr, cnt_wr, stat_wr, tick, hit;
    logic unused_addr;
    assign unused_addr = ^i_addr[1:0];
    assign wr = i_sel & i_we;
    assign ctrl_wr = wr && i_addr[3:2] == 2'd0;
    assign cmp_wr = wr && i_addr[3:2] == 2'd1;
    assign cnt_wr = wr && i_addr[3:2] == 2'd2;
    assign stat_wr = wr && i_addr[3:2] == 2'd3;
    assign tick = running && psc == prescale;
    // A software CNT write in the same cycle masks the compare entirely
    assign hit = tick && cnt == cmp && !cnt_wr;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = ctrl_wr ? (i_wdata[0] ? RUN : IDLE) : (hit && !ctrl_auto) ? DONE : state;
    end
    always_comb begin
        running = state == RUN;
        done = state == DONE;
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ctrl_en <= 1'b0;
            ctrl_auto <= 1'b0;
            ctrl_irq_en <= 1'b0;
            prescale <= '0;
            cmp <= 32'hFFFF_FFFF;
            cnt <= '0;
            match <= 1'b0;
            psc <= '0;
        end else begin
            if (ctrl_wr) begin
                ctrl_en <= i_wdata[0];
                ctrl_auto <= i_wdata[1];
                ctrl_irq_en <= i_wdata[2];
                prescale <= i_wdata[8 +: PRESCALE_W];
            end else if (hit && !ctrl_auto) begin
                ctrl_en <= 1'b0;
            end
            if (cmp_wr) cmp <= i_wdata;
            if (cnt_wr) cnt <= i_wdata;
            else if (tick) cnt <= hit ? (ctrl_auto ? '0 : cnt) : cnt + 32'd1;
            // Hardware set wins over a same-cycle write-1-to-clear
            match <= hit | (match & ~(stat_wr & i_wdata[0]));
            psc <= (ctrl_wr || tick || state_nx != RUN) ? '0 : psc + PRESCALE_W'(1);
        end
    end
    assign o_irq = match & ctrl_irq_en;
    always_comb begin
        o_rdata = !i_sel ? 32'h0 :
                  i_addr[3:2] == 2'd0 ? 32'({prescale, 5'b0, ctrl_irq_en, ctrl_auto, ctrl_en}) :
                  i_addr[3:2] == 2'd1 ? cmp :
                  i_addr[3:2] == 2'd2 ? cnt : {30'h0, done, match};
    end
endmodule

// File: tb/tb_timer_unit.sv
// tb_timer_unit: randomized and directed checks of timer_unit against a cycle-level behavioural model
module tb_timer_unit;
    logic i_clk = 1'b0, i_rst_n, i_sel, i_we, o_irq;
    logic [3:0] i_addr;
    logic [31:0] i_wdata, o_rdata;
    int total = 0, bad = 0;
    bit m_en, m_auto, m_irqen, m_running, m_done, m_match;
    logic [7:0] m_ps, m_phase;
    logic [31:0] m_cmp, m_cnt;

    timer_unit dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sel(i_sel), .i_we(i_we),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_irq(o_irq)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mread(input logic [3:0] a);
        case (a[3:2])
            2'd0: return {16'h0, m_ps, 5'h0, m_irqen, m_auto, m_en};
            2'd1: return m_cmp;
            2'd2: return m_cnt;
            default: return {30'h0, m_done, m_match};
        endcase
    endfunction

    function automatic bit m_irq();
        return m_match && m_irqen;
    endfunction

    function automatic bit m_tick_now();
        return m_running && m_phase == m_ps;
    endfunction

    task automatic model_step(input bit rst_n, input bit wr, input logic [3:0] a, input logic [31:0] d);
        bit tick, hit, aut;
        if (!rst_n) begin
            m_en = 0; m_auto = 0; m_irqen = 0; m_ps = 0; m_cmp = 32'hFFFF_FFFF;
            m_cnt = 0; m_match = 0; m_phase = 0; m_running = 0; m_done = 0;
            return;
        end
        tick = m_tick_now();
        hit = tick && m_cnt == m_cmp && !(wr && a[3:2] == 2'd2);
        aut = m_auto;
        if (hit) m_match = 1;
        else if (wr && a[3:2] == 2'd3 && d[0]) m_match = 0;
        if (wr && a[3:2] == 2'd2) m_cnt = d;
        else if (hit) m_cnt = aut ? 32'h0 : m_cnt;
        else if (tick) m_cnt = m_cnt + 32'd1;
        if (wr && a[3:2] == 2'd1) m_cmp = d;
        if (wr && a[3:2] == 2'd0) begin
            m_en = d[0]; m_auto = d[1]; m_irqen = d[2]; m_ps = d[15:8];
            m_running = d[0]; m_done = 0; m_phase = 0;
        end else if (hit && !aut) begin
            m_en = 0; m_running = 0; m_done = 1; m_phase = 0;
        end else if (m_running) begin
            m_phase = tick ? 8'h0 : m_phase + 8'h1;
        end
    endtask

    task automatic bus(input bit rst_n, input bit sel, input bit we, input logic [3:0] a, input logic [31:0] d);
        i_rst_n = rst_n; i_sel = sel; i_we = we; i_addr = a; i_wdata = d;
        @(posedge i_clk);
        model_step(rst_n, sel && we, a, d);
        #1;
        i_rst_n = 1; i_sel = 0; i_we = 0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus(1, 1, 1, a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) bus(1, 0, 0, 4'h0, 32'h0);
    endtask

    task automatic peek(input logic [3:0] a, output logic [31:0] v);
        i_sel = 1; i_we = 0; i_addr = a;
        #1;
        v = o_rdata;
        i_sel = 0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic [31:0] exp [4] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        bus(0, 0, 0, 4'h0, 32'h0);
        bus(0, 0, 0, 4'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            peek(4'(k * 4), v);
            total++;
            if (v !== exp[k]) begin bad++; $display("FAIL reset_reg%0d got=%h exp=%h", k, v, exp[k]); end
        end
        total++;
        if (o_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", o_irq); end
        i_sel = 0; i_addr = 4'h4;
        #1;
        total++;
        if (o_rdata !== 32'h0) begin bad++; $display("FAIL reset_unsel_rdata got=%h exp=0", o_rdata); end
    endtask

    task automatic test_auto_reload();
        logic [31:0] v;
        wr(4'h4, 32'd5);
        wr(4'h0, 32'h7);
        for (int i = 0; i < 14; i++) begin
            idle(1);
            peek(4'h8, v);
            total++;
            if (v !== 32'((i + 1) % 6) || v !== mread(4'h8)) begin
                bad++; $display("FAIL auto_cnt[%0d] got=%h exp=%h", i, v, (i + 1) % 6);
            end
            total++;
            if (o_irq !== (i >= 5) || o_irq !== m_irq()) begin
                bad++; $display("FAIL auto_irq[%0d] got=%b exp=%b", i, o_irq, i >= 5);
            end
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] v;
        wr(4'h0, 32'h0); wr(4'hC, 32'h1); wr(4'h8, 32'h0); wr(4'h4, 32'd3);
        wr(4'h0, 32'h201);
        for (int i = 0; i < 16; i++) begin
            idle(1);
            peek(4'h8, v);
            total++;
            if (v !== mread(4'h8)) begin bad++; $display("FAIL oneshot_cnt[%0d] got=%h exp=%h", i, v, mread(4'h8)); end
        end
        peek(4'hC, v);
        total++;
        if (v !== 32'h3) begin bad++; $display("FAIL oneshot_stat got=%h exp=3", v); end
        peek(4'h0, v);
        total++;
        if (v !== 32'h200) begin bad++; $display("FAIL oneshot_ctrl got=%h exp=200", v); end
        idle(4);
        peek(4'h8, v);
        total++;
        if (v !== 32'd3) begin bad++; $display("FAIL oneshot_hold got=%h exp=3", v); end
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        logic [31:0] exp [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2, 32'h0};
        wr(4'h0, 32'h0); wr(4'hC, 32'h1); wr(4'h4, 32'd2); wr(4'h8, 32'hFFFF_FFFE);
        wr(4'h0, 32'h3);
        for (int k = 0; k < 6; k++) begin
            peek(4'h8, v);
            total++;
            if (v !== exp[k]) begin bad++; $display("FAIL wrap_cnt[%0d] got=%h exp=%h", k, v, exp[k]); end
            peek(4'hC, v);
            total++;
            if (v[0] !== (k == 5)) begin bad++; $display("FAIL wrap_match[%0d] got=%b exp=%b", k, v[0], k == 5); end
            idle(1);
        end
    endtask

    task automatic test_w1c_race();
        logic [31:0] v;
        int n = 0;
        wr(4'h0, 32'h0); wr(4'hC, 32'h1); wr(4'h8, 32'h0); wr(4'h4, 32'd3);
        wr(4'h0, 32'h7);
        while (n < 20 && !(m_tick_now() && m_cnt == m_cmp)) begin idle(1); n++; end
        total++;
        if (n >= 20) begin bad++; $display("FAIL w1c_wait got=timeout exp=match_tick"); end
        wr(4'hC, 32'h1);
        peek(4'hC, v);
        total++;
        if (v[0] !== 1'b1) begin bad++; $display("FAIL w1c_race_match got=%b exp=1", v[0]); end
        total++;
        if (o_irq !== 1'b1) begin bad++; $display("FAIL w1c_race_irq got=%b exp=1", o_irq); end
        wr(4'hC, 32'h1);
        peek(4'hC, v);
        total++;
        if (v[0] !== 1'b0) begin bad++; $display("FAIL w1c_clear got=%b exp=0", v[0]); end
        total++;
        if (o_irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_drop got=%b exp=0", o_irq); end
    endtask

    task automatic test_cnt_write_race();
        logic [31:0] v;
        int n = 0;
        wr(4'h0, 32'h0); wr(4'hC, 32'h1); wr(4'h8, 32'h0); wr(4'h4, 32'd1000);
        wr(4'h0, 32'h203);
        while (n < 40 && !(m_tick_now() && m_cnt == 32'd7)) begin idle(1); n++; end
        total++;
        if (n >= 40) begin bad++; $display("FAIL cntwr_wait got=timeout exp=tick_at_7"); end
        wr(4'h8, 32'd100);
        peek(4'h8, v);
        total++;
        if (v !== 32'd100) begin bad++; $display("FAIL cntwr_value got=%0d exp=100", v); end
        idle(2);
        peek(4'h8, v);
        total++;
        if (v !== 32'd100) begin bad++; $display("FAIL cntwr_pre_tick got=%0d exp=100", v); end
        idle(1);
        peek(4'h8, v);
        total++;
        if (v !== 32'd101 || v !== mread(4'h8)) begin bad++; $display("FAIL cntwr_next_tick got=%0d exp=101", v); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int n = 0;
        logic [31:0] exp [4] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        wr(4'h0, 32'h0); wr(4'h8, 32'h0); wr(4'h4, 32'd2);
        wr(4'h0, 32'h7);
        idle(4);
        wr(4'h4, 32'd1000);
        wr(4'h8, 32'd5);
        while (n < 30 && m_cnt != 32'd9) begin idle(1); n++; end
        peek(4'h8, v);
        total++;
        if (v !== 32'd9 || o_irq !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%0d/%b exp=9/1", v, o_irq); end
        bus(0, 1, 1, 4'h8, 32'd77);
        for (int k = 0; k < 4; k++) begin
            peek(4'(k * 4), v);
            total++;
            if (v !== exp[k]) begin bad++; $display("FAIL rstmid_reg%0d got=%h exp=%h", k, v, exp[k]); end
        end
        total++;
        if (o_irq !== 1'b0) begin bad++; $display("FAIL rstmid_irq got=%b exp=0", o_irq); end
        idle(3);
        peek(4'h8, v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL rstmid_idle_cnt got=%h exp=0", v); end
    endtask

    task automatic test_random();
        logic [31:0] v, d;
        logic [3:0] a;
        for (int i = 0; i < 400; i++) begin
            a = 4'($urandom);
            case (a[3:2])
                2'd0: d = ($urandom & 32'hFFFF_00F8) | (32'($urandom_range(0, 3)) << 8) | 32'($urandom_range(0, 7));
                2'd1: d = 32'($urandom_range(0, 12));
                2'd2: d = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 12));
                default: d = $urandom;
            endcase
            bus($urandom_range(0, 99) >= 2, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7, a, d);
            a = 4'($urandom);
            peek(a, v);
            total++;
            if (v !== mread(a)) begin bad++; $display("FAIL rand_read[%0d] a=%h got=%h exp=%h", i, a, v, mread(a)); end
            total++;
            if (o_irq !== m_irq()) begin bad++; $display("FAIL rand_irq[%0d] got=%b exp=%b", i, o_irq, m_irq()); end
            if (i % 16 == 0) begin
                i_sel = 0; i_addr = 4'($urandom);
                #1;
                total++;
                if (o_rdata !== 32'h0) begin bad++; $display("FAIL rand_unsel[%0d] got=%h exp=0", i, o_rdata); end
            end
        end
    endtask

    initial begin
        i_rst_n = 0; i_sel = 0; i_we = 0; i_addr = 4'h0; i_wdata = 32'h0;
        test_reset();
        test_auto_reload();
        test_one_shot();
        test_wrap();
        test_w1c_race();
        test_cnt_write_race();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/timer_unit.md
TIMER_UNIT -- requirements
Module: timer_unit

Interface
Parameters:
REQ-001 SHALL have parameter PRESCALE_W, default 8: width of prescaler counter and CTRL.PRESCALE field.
Ports:
REQ-002 SHALL have port i_clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port i_sel, input, 1: timer select, driven by the SoC device-select output for device 4'h6.
REQ-005 SHALL have port i_we, input, 1: write enable, qualified by i_sel.
REQ-006 SHALL have port i_addr, input, 4: byte offset within the timer window; bits [3:2] select the register, bits [1:0] are ignored.
REQ-007 SHALL have port i_wdata, input, 32: write data.
REQ-008 SHALL have port o_rdata, output, 32: read data, returned to the device-select mux as the timer read data.
REQ-009 SHALL have port o_irq, output, 1: level interrupt.

Function
REQ-010 SHALL implement the following register map:
- 0x0 CTRL: bit0 EN, bit1 AUTO, bit2 IRQ_EN, bits[8+PRESCALE_W-1:8] PRESCALE; other bits read as 0.
- 0x4 CMP: 32-bit compare value.
- 0x8 CNT: 32-bit counter, read/write.
- 0xC STAT: bit0 MATCH, sticky; writing 1 clears it and writing 0 has no effect; bit1 DONE, read-only.
REQ-011 SHALL make o_rdata combinational from i_sel and i_addr[3:2], with zero wait states; o_rdata SHALL be 32'h0 when i_sel=0.
REQ-012 SHALL apply register writes on the rising edge where i_sel=1 and i_we=1; the written value SHALL be visible on the next cycle.
REQ-013 SHALL implement FSM states IDLE, RUN and DONE, encoded in 2 bits.
REQ-014 SHALL define the FSM transitions as follows:
- IDLE->RUN when CTRL.EN is written 1.
- RUN->IDLE when CTRL.EN is written 0.
- RUN->DONE on a match when AUTO=0.
- DONE->IDLE when CTRL.EN is written 0.
- DONE->RUN when CTRL.EN is written 1 while already in DONE.
REQ-015 SHALL, in RUN only, advance the prescaler counter each cycle; it SHALL wrap to 0 after reaching PRESCALE, and a tick SHALL be asserted in the cycle it equals PRESCALE, giving a tick period of PRESCALE+1 cycles.
REQ-016 SHALL, on a tick with CNT==CMP, set MATCH and then:
- if AUTO=1, load CNT with 0;
- if AUTO=0, hold CNT, clear CTRL.EN, and enter DONE.
REQ-017 SHALL, on a tick with CNT!=CMP, increment CNT modulo 2^32, so 32'hFFFF_FFFF wraps to 32'h0 with no flag.
REQ-018 SHALL clear the prescaler counter to 0 on any CTRL write and on every exit from RUN.
REQ-019 SHALL give a software CNT write priority over a same-cycle tick increment or reload, and SHALL suppress the match check in that cycle.
REQ-020 SHALL give hardware MATCH set priority over a same-cycle software write-1-to-clear.
REQ-021 SHALL give a same-cycle CMP write effect from the next tick onward; the current-cycle compare SHALL use the old CMP.
REQ-022 SHALL drive o_irq = MATCH & IRQ_EN from registered state, with no combinational path from bus inputs.
REQ-023 SHALL reflect STAT.DONE as 1 exactly when the FSM is in DONE.

Reset
REQ-024 SHALL, while i_rst_n=0 at a rising edge, load CTRL=0, CMP=32'hFFFF_FFFF, CNT=0, MATCH=0, prescaler=0 and FSM=IDLE.
REQ-025 SHALL hold o_irq=0 after reset, and o_rdata SHALL follow REQ-011 using the reset register values.
REQ-026 SHALL apply reset asserted mid-count on the next edge, overriding any same-cycle bus write; no tick SHALL be issued in that cycle.

Verification
REQ-027 SHALL pass: write CMP=5, then CTRL=0x07 (PRESCALE=0, EN, AUTO, IRQ_EN) -> CNT steps 0..5, MATCH and o_irq rise on the tick at CNT=5, CNT returns to 0, and the sequence repeats every 6 cycles.
REQ-028 SHALL pass: write CMP=3, then CTRL=0x0000_0201 (PRESCALE=2, one-shot) -> CNT increments every 3 cycles and reaches 3, then STAT reads 0x3, CTRL.EN reads 0 and CNT holds at 3.
REQ-029 SHALL pass: preload CNT=32'hFFFF_FFFE with CMP=2 and AUTO=1 -> sequence FFFF_FFFE, FFFF_FFFF, 0, 1, 2, with MATCH set at 2.
REQ-030 SHALL pass: write STAT=0x1 in the same cycle as a match tick -> MATCH reads 1 afterwards; a subsequent write STAT=0x1 clears it and o_irq drops on the next cycle.
REQ-031 SHALL pass: write CNT=100 in the same cycle as a tick at CNT=7 -> CNT reads 100 and no increment is lost or doubled on the next tick (101).
REQ-032 SHALL pass: assert i_rst_n=0 for 1 cycle while in RUN at CNT=9 -> all registers read their REQ-024 values, o_irq=0 and the FSM is IDLE.
